// File: rtl/led_bus_arbiter.sv
// Round-robin LED/PMOD bus arbiter with a tick-based minimum ownership slot.
// Define LED_ARB_BLANK_EN to stretch the inter-owner blank until the next prescaler tick.
module led_bus_arbiter #(
    parameter int               NREQ         = 4,
    parameter int               WIDTH        = 8,
    parameter int               DIV          = 22,
    parameter int               HOLD         = 4,
    parameter logic [WIDTH-1:0] IDLE_PATTERN = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       REQ,
    input  logic [NREQ*WIDTH-1:0] PAT,
    output logic [NREQ-1:0]       GNT,
    output logic [WIDTH-1:0]      OUT,
    output logic                  TICK,
    output logic                  BUSY
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HW = $clog2(HOLD + 1);

    typedef enum logic [1:0] {S_IDLE, S_OWN, S_GAP} state_t;

    state_t           state;
    logic [DIV-1:0]   presc;
    logic [DIV-1:0]   presc_nxt;
    logic [HW-1:0]    hold;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    owner;
    logic [PW-1:0]    pick;
    logic [PW-1:0]    idx;
    logic             pick_valid;
    logic             gap_done;
    logic             start;
    logic             preempt;
    logic             release_bus;
    logic [WIDTH-1:0] pat_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_pat
        assign pat_arr[i] = PAT[i*WIDTH +: WIDTH];
    end

    assign presc_nxt = presc + 1'b1;

    // TICK is registered so it is high in exactly the cycle the prescaler reads all-ones.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc <= '0;
            TICK  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
            presc <= presc_nxt;
            TICK  <= (presc_nxt == '1);
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one unassigned (no latch).
        pick_valid = 1'b0;
        pick       = ptr;
        idx        = ptr;
        for (int k = 0; k < NREQ; k++) begin
            idx = (idx == PW'(NREQ - 1)) ? '0 : idx + 1'b1;
            if (!pick_valid && REQ[idx]) begin
                pick_valid = 1'b1;
                pick       = idx;
            end
        end
    end

`ifdef LED_ARB_BLANK_EN
    assign gap_done = TICK;
`else
    assign gap_done = 1'b1;
`endif

    assign start       = (state == S_IDLE) || ((state == S_GAP) && gap_done);
    assign release_bus = !REQ[owner];
    // With a single requester REQ & ~GNT is always zero, so preemption never fires.
    assign preempt     = (hold == HW'(HOLD)) && ((REQ & ~GNT) != '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
            ptr   <= PW'(NREQ - 1);
            owner <= '0;
            hold  <= '0;
            GNT   <= '0;
            OUT   <= IDLE_PATTERN;
            BUSY  <= 1'b0;
        end else begin
            case (state)
                S_OWN: begin
                    if (release_bus || preempt) begin
                        state <= S_GAP;
                        GNT   <= '0;
                        OUT   <= IDLE_PATTERN;
                        BUSY  <= 1'b0;
                    end else begin
                        OUT <= pat_arr[owner];
                        if (TICK && (hold != HW'(HOLD))) begin
                            hold <= hold + 1'b1;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        if (pick_valid) begin
                            state <= S_OWN;
                            owner <= pick;
                            ptr   <= pick;
                            hold  <= '0;
                            GNT   <= NREQ'(1) << pick;
                            OUT   <= pat_arr[pick];
                            BUSY  <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end
endmodule
